// File: rtl/fsm_seq_checker.sv
// Golden-copy observer for the 4-state odd/even sequencer.
// Runs its own copy of the sequence from the shared pause/restart inputs, compares the
// sequencer's state and decoded outputs every cycle, and keeps error/sequence counters.
module fsm_seq_checker #(
    parameter int unsigned CNT_W  = 8,
    parameter bit          RESYNC = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             restart,
    input  logic [1:0]       dut_state,
    input  logic             dut_odd,
    input  logic             dut_even,
    input  logic             dut_terminal,
    output logic [1:0]       exp_state,
    output logic             state_err,
    output logic             decode_err,
    output logic             sticky_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] seq_count
);

    localparam logic [1:0] S1 = 2'b11;
    localparam logic [1:0] S2 = 2'b01;
    localparam logic [1:0] S3 = 2'b10;
    localparam logic [1:0] S4 = 2'b00;

    logic [1:0]       exp_state_q, exp_state_d;
    logic             state_err_q, decode_err_q, sticky_err_q;
    logic [CNT_W-1:0] err_count_q, seq_count_q;

    logic       dut_valid;
    logic [2:0] exp_dec;
    logic       state_mis, decode_mis, err_any;
    logic [1:0] base_state, succ_state;
    logic       wrap;

    // Decode check on the DUT's own state; case items match exactly, so X/Z fall to default
    // and count as a mismatch.
    always_comb begin
        dut_valid  = 1'b0;
        exp_dec    = 3'b000;  // {odd, even, terminal}
        decode_mis = 1'b1;
        case (dut_state)
            S1: begin dut_valid = 1'b1; exp_dec = 3'b100; end
            S2: begin dut_valid = 1'b1; exp_dec = 3'b010; end
            S3: begin dut_valid = 1'b1; exp_dec = 3'b100; end
            S4: begin dut_valid = 1'b1; exp_dec = 3'b011; end
            default: ;
        endcase
        if (dut_valid) begin
            case ({dut_odd, dut_even, dut_terminal})
                exp_dec: decode_mis = 1'b0;
                default: ;
            endcase
        end
        state_mis = !(dut_valid && (dut_state == exp_state_q));
        err_any   = state_mis || decode_mis;
    end

    // Golden next state; with RESYNC the copy re-locks onto a valid DUT state after a mismatch.
    always_comb begin
        base_state = (RESYNC && state_mis && dut_valid) ? dut_state : exp_state_q;
        case (base_state)
            S1:      succ_state = S2;
            S2:      succ_state = S3;
            S3:      succ_state = S4;
            default: succ_state = S1;
        endcase
        wrap = 1'b0;
        if (restart) begin
            exp_state_d = S1;
        end else if (pause) begin
            exp_state_d = base_state;
        end else begin
            exp_state_d = succ_state;
            wrap        = (base_state == S4);
        end
    end

    // Registered error pulses, sticky flag and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_state_q  <= S1;
            state_err_q  <= 1'b0;
            decode_err_q <= 1'b0;
            sticky_err_q <= 1'b0;
            err_count_q  <= '0;
            seq_count_q  <= '0;
        end else begin
            exp_state_q  <= exp_state_d;
            state_err_q  <= state_mis;
            decode_err_q <= decode_mis;
            if (err_any) begin
                sticky_err_q <= 1'b1;
                if (err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
            end
            if (wrap && (seq_count_q != '1)) seq_count_q <= seq_count_q + CNT_W'(1);
        end
    end

    assign exp_state  = exp_state_q;
    assign state_err  = state_err_q;
    assign decode_err = decode_err_q;
    assign sticky_err = sticky_err_q;
    assign err_count  = err_count_q;
    assign seq_count  = seq_count_q;

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Bench for fsm_seq_checker: two instances (8-bit/RESYNC=1 and 2-bit/RESYNC=0) share one
// stimulus stream and are compared every cycle against a sequence-level reference model.
module tb_fsm_seq_checker;

    logic       clk = 1'b0;
    logic       rst, pause, restart;
    logic [1:0] dut_state;
    logic       dut_odd, dut_even, dut_terminal;

    logic [1:0] exp_state_a, exp_state_b;
    logic       state_err_a, decode_err_a, sticky_err_a;
    logic       state_err_b, decode_err_b, sticky_err_b;
    logic [7:0] err_count_a, seq_count_a;
    logic [1:0] err_count_b, seq_count_b;

    always #5 clk = ~clk;

    fsm_seq_checker #(.CNT_W(8), .RESYNC(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .pause(pause), .restart(restart),
        .dut_state(dut_state), .dut_odd(dut_odd), .dut_even(dut_even),
        .dut_terminal(dut_terminal), .exp_state(exp_state_a), .state_err(state_err_a),
        .decode_err(decode_err_a), .sticky_err(sticky_err_a), .err_count(err_count_a),
        .seq_count(seq_count_a)
    );

    fsm_seq_checker #(.CNT_W(2), .RESYNC(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .pause(pause), .restart(restart),
        .dut_state(dut_state), .dut_odd(dut_odd), .dut_even(dut_even),
        .dut_terminal(dut_terminal), .exp_state(exp_state_b), .state_err(state_err_b),
        .decode_err(decode_err_b), .sticky_err(sticky_err_b), .err_count(err_count_b),
        .seq_count(seq_count_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 -> instance a, 1 -> instance b.
    logic [1:0] m_exp[2];
    bit         m_serr[2], m_derr[2], m_sticky[2];
    int         m_errc[2], m_seqc[2];
    int         m_max[2]    = '{255, 3};
    bit         m_resync[2] = '{1'b1, 1'b0};

    // Stimulus-side sequencer position (0..3 = S1..S4) and fault injection controls.
    int         drv_idx   = 0;
    bit         cor_state = 1'b0;
    logic [1:0] cor_val   = 2'b00;
    bit         cor_dec   = 1'b0;

    function automatic logic [1:0] enc(input int i);
        case (i % 4)
            0:       return 2'b11;
            1:       return 2'b01;
            2:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] succ(input logic [1:0] s);
        for (int i = 0; i < 4; i++) if (enc(i) == s) return enc(i + 1);
        return 2'b11;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input int k);
        logic [1:0] ds, base, nxt;
        bit         smis, dmis, odd_e;
        if (rst) begin
            m_exp[k] = 2'b11; m_serr[k] = 0; m_derr[k] = 0; m_sticky[k] = 0;
            m_errc[k] = 0; m_seqc[k] = 0;
        end else begin
            ds    = dut_state;
            smis  = (ds != m_exp[k]);
            odd_e = (ds == 2'b11) || (ds == 2'b10);
            dmis  = (dut_odd != odd_e) || (dut_even != !odd_e) || (dut_terminal != (ds == 2'b00));
            base  = (m_resync[k] && smis) ? ds : m_exp[k];
            if (restart) begin
                nxt = 2'b11;
            end else if (pause) begin
                nxt = base;
            end else begin
                nxt = succ(base);
                if (base == 2'b00 && m_seqc[k] < m_max[k]) m_seqc[k]++;
            end
            m_serr[k] = smis;
            m_derr[k] = dmis;
            if (smis || dmis) begin
                m_sticky[k] = 1;
                if (m_errc[k] < m_max[k]) m_errc[k]++;
            end
            m_exp[k] = nxt;
        end
    endtask

    task automatic compare_all();
        chk("a.exp_state",  exp_state_a,  m_exp[0]);
        chk("a.state_err",  state_err_a,  m_serr[0]);
        chk("a.decode_err", decode_err_a, m_derr[0]);
        chk("a.sticky_err", sticky_err_a, m_sticky[0]);
        chk("a.err_count",  err_count_a,  m_errc[0]);
        chk("a.seq_count",  seq_count_a,  m_seqc[0]);
        chk("b.exp_state",  exp_state_b,  m_exp[1]);
        chk("b.state_err",  state_err_b,  m_serr[1]);
        chk("b.decode_err", decode_err_b, m_derr[1]);
        chk("b.sticky_err", sticky_err_b, m_sticky[1]);
        chk("b.err_count",  err_count_b,  m_errc[1]);
        chk("b.seq_count",  seq_count_b,  m_seqc[1]);
    endtask

    // Drive one cycle of stimulus, advance models at the edge, compare 1 time unit later.
    task automatic step(input bit r, input bit p, input bit rs);
        logic [1:0] s;
        bit         odd;
        s       = enc(drv_idx);
        odd     = (s == 2'b11) || (s == 2'b10);
        rst     = r;
        pause   = p;
        restart = rs;
        dut_state    = cor_state ? cor_val : s;
        dut_odd      = cor_dec ? !odd : odd;
        dut_even     = cor_dec ? odd : !odd;
        dut_terminal = (s == 2'b00);
        @(posedge clk);
        model_update(0);
        model_update(1);
        if (r || rs) drv_idx = 0;
        else if (!p) drv_idx = (drv_idx + 1) % 4;
        #1;
        compare_all();
    endtask

    initial begin
        // Reset state
        step(1, 0, 0);
        chk("rst.exp_state", exp_state_a, 2'b11);
        chk("rst.err_count", err_count_a, 0);
        chk("rst.seq_count", seq_count_a, 0);
        chk("rst.sticky",    sticky_err_a, 0);

        // Compliant run, 8 cycles: two S4->S1 wraps
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0);
            chk("seq.exp_state", exp_state_a, enc(k));
        end
        chk("seq.seq_count", seq_count_a, 2);
        chk("seq.err_count", err_count_a, 0);

        // Pause held 3 cycles in S3
        step(0, 0, 0);
        step(0, 0, 0);
        chk("pause.pre", exp_state_a, 2'b10);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0);
            chk("pause.hold", exp_state_a, 2'b10);
            chk("pause.serr", state_err_a, 0);
        end
        step(0, 0, 0);
        chk("pause.release", exp_state_a, 2'b00);

        // restart + pause together in S2
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rstrt.pre", exp_state_a, 2'b01);
        step(0, 1, 1);
        chk("rstrt.exp_state", exp_state_a, 2'b11);
        chk("rstrt.seq_count", seq_count_a, 3);

        // DUT jumps to S4 while S2 expected; RESYNC=1 re-locks
        step(0, 0, 0);
        drv_idx = 3;
        step(0, 0, 0);
        chk("jump.serr",      state_err_a, 1);
        chk("jump.err_count", err_count_a, 1);
        chk("jump.sticky",    sticky_err_a, 1);
        chk("jump.exp_state", exp_state_a, 2'b11);
        step(0, 0, 0);
        chk("jump.clean",     state_err_a, 0);
        chk("jump.err_hold",  err_count_a, 1);

        // Decode fault in S3: even=1, odd=0
        step(0, 0, 0);
        chk("dec.pre", exp_state_a, 2'b10);
        cor_dec = 1;
        step(0, 0, 0);
        cor_dec = 0;
        chk("dec.derr",      decode_err_a, 1);
        chk("dec.serr",      state_err_a, 0);
        chk("dec.err_count", err_count_a, 2);

        // Saturation on the 2-bit instance, then reset mid-run
        step(1, 0, 0);
        cor_dec = 1;
        for (int k = 0; k < 5; k++) step(0, 0, 0);
        chk("sat.err_count_b", err_count_b, 3);
        chk("sat.err_count_a", err_count_a, 5);
        step(1, 0, 0);
        cor_dec = 0;
        chk("sat.rst_err_b",   err_count_b, 0);
        chk("sat.rst_sticky",  sticky_err_b, 0);
        chk("sat.rst_exp",     exp_state_b, 2'b11);
        chk("sat.rst_derr",    decode_err_b, 0);

        // Randomized phase
        for (int n = 0; n < 800; n++) begin
            cor_state = ($urandom_range(0, 11) == 0);
            cor_val   = 2'($urandom_range(0, 3));
            cor_dec   = ($urandom_range(0, 11) == 0);
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
